tdc_slope_corrector: RTL and testbench

TDC_SLOPE_CORRECTOR -- requirements
Module: tdc_slope_corrector

---
 rtl/tdc_slope_corrector.sv | 205 ++++++++++++++++++++
 tb/tb_tdc_slope_corrector.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_slope_corrector.sv
// ============================================================================
// tdc_slope_corrector : per-channel piecewise-linear slope correction of TDC
//                       rise times around a mid address, with output clamping.
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tdc_slope_corrector #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 11,
   parameter int COEF_W   = 16,
   parameter int NCH      = 4,
   parameter int SHIFT    = 10,
   parameter int MULT_LAT = 3,
   localparam int c_CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              i_clk_50m,
   input  logic              i_rst_n,
   input  logic              i_cfg_we,
   input  logic [c_CH_W-1:0] i_cfg_ch,
   input  logic              i_cfg_sel,
   input  logic [COEF_W-1:0] i_cfg_data,
   input  logic              i_req,
   output logic              o_ready,
   input  logic [c_CH_W-1:0] i_ch,
   input  logic              i_post_sign,
   input  logic              i_now_sign,
   input  logic [ADDR_W-1:0] i_addr_mid,
   input  logic [ADDR_W-1:0] i_tdc_rd_addr,
   input  logic [DATA_W-1:0] i_rise_data,
   output logic              o_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_data,
   output logic              o_sat,
   output logic [c_CH_W-1:0] o_ch
);

   localparam int c_PW = COEF_W + ADDR_W;
   localparam int c_SW = DATA_W + ADDR_W + COEF_W;

   localparam logic [2:0] c_IDLE = 3'd0;
   localparam logic [2:0] c_DIFF = 3'd1;
   localparam logic [2:0] c_MULT = 3'd2;
   localparam logic [2:0] c_ADJ  = 3'd3;
   localparam logic [2:0] c_OUT  = 3'd4;

   localparam logic [1:0] c_M_EQ    = 2'd0;
   localparam logic [1:0] c_M_BELOW = 2'd1;
   localparam logic [1:0] c_M_ABOVE = 2'd2;

   localparam logic signed [c_SW-1:0] c_MAXV = {{(c_SW-DATA_W){1'b0}}, {DATA_W{1'b1}}};

   logic [2:0]        state_q, state_d;
   logic [COEF_W-1:0] coef_lo_q [NCH];
   logic [COEF_W-1:0] coef_hi_q [NCH];
   logic [c_CH_W-1:0] ch_q;
   logic              post_q, now_q;
   logic [ADDR_W-1:0] mid_q, addr_q, len_q;
   logic [DATA_W-1:0] rise_q;
   logic [COEF_W-1:0] clo_q, chi_q, coef_q;
   logic [1:0]        mode_q;
   logic [3:0]        cnt_q;
   logic [c_PW-1:0]   prod_q [MULT_LAT];
   logic [DATA_W-1:0] data_q;
   logic              sat_q;
   logic [c_CH_W-1:0] och_q;

   logic [c_CH_W-1:0]      w_ch_sel;
   logic [c_PW-1:0]        w_prod;
   logic [c_PW-1:0]        w_off;
   logic                   w_sub;
   logic signed [c_SW-1:0] w_rise_x, w_off_x, w_sum;
   logic [DATA_W-1:0]      w_res;
   logic                   w_sat;

   assign w_ch_sel = (int'(i_ch) < NCH) ? i_ch : '0;

   // Coefficient bank: out-of-range channel writes are dropped.
   always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            coef_lo_q[i] <= '0;
            coef_hi_q[i] <= '0;
         end
      end else if (i_cfg_we && (int'(i_cfg_ch) < NCH)) begin
         if (i_cfg_sel) coef_hi_q[i_cfg_ch] <= i_cfg_data;
         else           coef_lo_q[i_cfg_ch] <= i_cfg_data;
      end
   end

   always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= c_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_IDLE: if (i_req) state_d = c_DIFF;
         c_DIFF: state_d = (addr_q == mid_q) ? c_ADJ : c_MULT;
         c_MULT: if (cnt_q == 4'(MULT_LAT - 1)) state_d = c_ADJ;
         c_ADJ:  state_d = c_OUT;
         c_OUT:  if (i_out_ready) state_d = c_IDLE;
         default: state_d = c_IDLE;
      endcase
   end

   always_comb begin
      o_ready = (state_q == c_IDLE);
      o_valid = (state_q == c_OUT);
   end

   assign w_prod = c_PW'(coef_q) * c_PW'(len_q);

   // Free-running product pipeline; operands are frozen for the whole MULT phase.
   always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < MULT_LAT; i++) prod_q[i] <= '0;
      end else begin
         prod_q[0] <= w_prod;
         for (int i = MULT_LAT - 1; i > 0; i--) prod_q[i] <= prod_q[i-1];
      end
   end

   assign w_off    = prod_q[MULT_LAT-1] >> SHIFT;
   assign w_rise_x = $signed(c_SW'(rise_q));
   assign w_off_x  = $signed(c_SW'(w_off));
   assign w_sub    = (mode_q == c_M_BELOW) ? post_q : !now_q;

   always_comb begin
      w_sum = w_rise_x;
      if (mode_q != c_M_EQ) w_sum = w_sub ? (w_rise_x - w_off_x) : (w_rise_x + w_off_x);
      w_res = w_sum[DATA_W-1:0];
      w_sat = 1'b0;
      if (w_sum < 0) begin
         w_res = '0;
         w_sat = 1'b1;
      end else if (w_sum > c_MAXV) begin
         w_res = '1;
         w_sat = 1'b1;
      end
   end

   always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ch_q   <= '0;
         post_q <= 1'b0;
         now_q  <= 1'b0;
         mid_q  <= '0;
         addr_q <= '0;
         rise_q <= '0;
         clo_q  <= '0;
         chi_q  <= '0;
         mode_q <= c_M_EQ;
         len_q  <= '0;
         coef_q <= '0;
         cnt_q  <= '0;
         data_q <= '0;
         sat_q  <= 1'b0;
         och_q  <= '0;
      end else begin
         case (state_q)
            c_IDLE: if (i_req) begin
               ch_q   <= w_ch_sel;
               post_q <= i_post_sign;
               now_q  <= i_now_sign;
               mid_q  <= i_addr_mid;
               addr_q <= i_tdc_rd_addr;
               rise_q <= i_rise_data;
               clo_q  <= coef_lo_q[w_ch_sel];
               chi_q  <= coef_hi_q[w_ch_sel];
            end
            c_DIFF: begin
               cnt_q <= '0;
               if (addr_q < mid_q) begin
                  mode_q <= c_M_BELOW;
                  len_q  <= mid_q - addr_q;
                  coef_q <= clo_q;
               end else if (addr_q > mid_q) begin
                  mode_q <= c_M_ABOVE;
                  len_q  <= addr_q - mid_q;
                  coef_q <= chi_q;
               end else begin
                  mode_q <= c_M_EQ;
               end
            end
            c_MULT: cnt_q <= cnt_q + 4'd1;
            c_ADJ: begin
               data_q <= w_res;
               sat_q  <= w_sat;
               och_q  <= ch_q;
            end
            default: ;
         endcase
      end
   end

   assign o_data = data_q;
   assign o_sat  = sat_q;
   assign o_ch   = och_q;

endmodule

`default_nettype wire

// File: tb/tb_tdc_slope_corrector.sv
// ============================================================================
// tb_tdc_slope_corrector : scoreboard bench, directed cases plus random traffic.
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tdc_slope_corrector;
   localparam int DATA_W = 16, ADDR_W = 11, COEF_W = 16, NCH = 4, SHIFT = 10, MULT_LAT = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_cfg_we = 1'b0, i_cfg_sel = 1'b0;
   logic [1:0]        i_cfg_ch = '0, i_ch = '0;
   logic [COEF_W-1:0] i_cfg_data = '0;
   logic              i_req = 1'b0, i_post_sign = 1'b0, i_now_sign = 1'b0, i_out_ready = 1'b1;
   logic [ADDR_W-1:0] i_addr_mid = '0, i_tdc_rd_addr = '0;
   logic [DATA_W-1:0] i_rise_data = '0;
   logic              o_ready, o_valid, o_sat;
   logic [DATA_W-1:0] o_data;
   logic [1:0]        o_ch;

   tdc_slope_corrector #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .COEF_W(COEF_W),
      .NCH(NCH), .SHIFT(SHIFT), .MULT_LAT(MULT_LAT)
   ) dut (
      .i_clk_50m(clk), .i_rst_n(rst_n),
      .i_cfg_we(i_cfg_we), .i_cfg_ch(i_cfg_ch), .i_cfg_sel(i_cfg_sel), .i_cfg_data(i_cfg_data),
      .i_req(i_req), .o_ready(o_ready), .i_ch(i_ch),
      .i_post_sign(i_post_sign), .i_now_sign(i_now_sign),
      .i_addr_mid(i_addr_mid), .i_tdc_rd_addr(i_tdc_rd_addr), .i_rise_data(i_rise_data),
      .o_valid(o_valid), .i_out_ready(i_out_ready),
      .o_data(o_data), .o_sat(o_sat), .o_ch(o_ch)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic [15:0] d;
      logic        s;
      logic [1:0]  ch;
      int          acc;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0, n_fail = 0;
   int   cyc = 0;
   int   ref_lo[NCH], ref_hi[NCH];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Behavioural reference: piecewise-linear correction around mid, then clamp.
   function automatic void model(input int ch, input bit post, input bit now,
                                 input int mid, input int addr, input int rise,
                                 output logic [15:0] d, output logic s, output int lat);
      longint off, r;
      r   = rise;
      lat = MULT_LAT + 3;
      if (addr < mid) begin
         off = (longint'(ref_lo[ch]) * (mid - addr)) / 1024;
         r   = post ? rise - off : rise + off;
      end else if (addr > mid) begin
         off = (longint'(ref_hi[ch]) * (addr - mid)) / 1024;
         r   = now ? rise + off : rise - off;
      end else begin
         lat = 3;
      end
      s = (r < 0) || (r > 65535);
      d = (r < 0) ? 16'd0 : (r > 65535) ? 16'hFFFF : 16'(r);
   endfunction

   // Monitor: the accept cycle counts as the first of LAT cycles, so o_valid
   // first shows LAT-1 edges after the accepting edge.
   initial begin
      bit prev_v;
      prev_v = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && o_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_valid", 64'(o_valid), 64'd0);
            end else begin
               if (!prev_v) check("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat - 1));
               check("data", 64'(o_data), 64'(sb[0].d));
               check("sat", 64'(o_sat), 64'(sb[0].s));
               check("ch", 64'(o_ch), 64'(sb[0].ch));
               check("ready_low_in_out", 64'(o_ready), 64'd0);
               if (i_out_ready) void'(sb.pop_front());
            end
            prev_v = !i_out_ready;
         end else begin
            prev_v = 1'b0;
         end
      end
   end

   // Caller is positioned 2 ns after a rising edge.
   task automatic do_req(input int ch, input bit post, input bit now, input int mid,
                         input int addr, input int rise, input logic [15:0] d,
                         input logic s, input int lat, output int waits);
      i_ch = 2'(ch); i_post_sign = post; i_now_sign = now;
      i_addr_mid = 11'(mid); i_tdc_rd_addr = 11'(addr); i_rise_data = 16'(rise);
      i_req = 1'b1;
      waits = 0;
      while (!o_ready && waits < 100) begin
         @(posedge clk); #2;
         waits++;
      end
      if (!o_ready) check("accept_timeout", 64'(o_ready), 64'd1);
      else sb.push_back('{d, s, 2'(ch), cyc + 1, lat});
      @(posedge clk); #2;
      i_req = 1'b0;
   endtask

   task automatic wr(input int ch, input bit sel, input int data);
      i_cfg_we = 1'b1; i_cfg_ch = 2'(ch); i_cfg_sel = sel; i_cfg_data = 16'(data);
      @(posedge clk); #2;
      i_cfg_we = 1'b0;
      if (sel) ref_hi[ch] = data; else ref_lo[ch] = data;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 400) begin
         @(posedge clk); #2;
         n++;
      end
      check("drain_queue_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, n, acc_n, guard, mid, addr, rise, ch;
      bit pend;
      logic [15:0] ed;
      logic es;
      int elat;
      for (int i = 0; i < NCH; i++) begin ref_lo[i] = 0; ref_hi[i] = 0; end

      repeat (3) @(posedge clk);
      #2;
      check("rst_valid", 64'(o_valid), 64'd0);
      check("rst_data", 64'(o_data), 64'd0);
      check("rst_sat", 64'(o_sat), 64'd0);
      check("rst_ch", 64'(o_ch), 64'd0);
      rst_n = 1'b1;
      check("rst_ready", 64'(o_ready), 64'd1);

      wr(0, 0, 1024);
      wr(2, 1, 2048);
      do_req(0, 1, 0, 100, 90, 5000, 16'd4990, 1'b0, 6, w);   drain();
      do_req(2, 0, 1, 100, 110, 5000, 16'd5020, 1'b0, 6, w);  drain();
      do_req(2, 0, 0, 100, 110, 5000, 16'd4980, 1'b0, 6, w);  drain();
      do_req(1, 0, 0, 100, 100, 1234, 16'd1234, 1'b0, 3, w);  drain();
      do_req(0, 1, 0, 100, 90, 5, 16'd0, 1'b1, 6, w);         drain();
      do_req(0, 0, 0, 100, 90, 65530, 16'd65535, 1'b1, 6, w); drain();

      // Write coinciding with the accept: old coefficient applies, new one afterwards.
      i_cfg_we = 1'b1; i_cfg_ch = 2'd0; i_cfg_sel = 1'b0; i_cfg_data = 16'd0;
      do_req(0, 1, 0, 100, 90, 5000, 16'd4990, 1'b0, 6, w);
      i_cfg_we = 1'b0;
      ref_lo[0] = 0;
      drain();
      do_req(0, 1, 0, 100, 90, 5000, 16'd5000, 1'b0, 6, w); drain();
      wr(0, 0, 1024);

      // Back-pressure.
      i_out_ready = 1'b0;
      do_req(2, 0, 1, 100, 110, 5000, 16'd5020, 1'b0, 6, w);
      n = 0;
      while (!o_valid && n < 50) begin @(posedge clk); #2; n++; end
      check("bp_valid_seen", 64'(o_valid), 64'd1);
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #2;
         check("bp_valid_hold", 64'(o_valid), 64'd1);
         check("bp_data_hold", 64'(o_data), 64'd5020);
         check("bp_ready_low", 64'(o_ready), 64'd0);
      end
      i_out_ready = 1'b1;
      drain();

      // Asynchronous reset while the multiplier is busy.
      do_req(2, 0, 1, 100, 110, 5000, 16'd5020, 1'b0, 6, w);
      @(posedge clk); #5;
      rst_n = 1'b0;
      #1;
      sb.delete();
      for (int i = 0; i < NCH; i++) begin ref_lo[i] = 0; ref_hi[i] = 0; end
      check("arst_valid", 64'(o_valid), 64'd0);
      check("arst_data", 64'(o_data), 64'd0);
      check("arst_sat", 64'(o_sat), 64'd0);
      check("arst_ch", 64'(o_ch), 64'd0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #2;
         check("arst_valid_hold", 64'(o_valid), 64'd0);
      end
      rst_n = 1'b1;
      check("arst_ready", 64'(o_ready), 64'd1);
      do_req(2, 0, 1, 100, 110, 5000, 16'd5000, 1'b0, 6, w);
      check("first_accept_no_wait", 64'(w), 64'd0);
      drain();

      // Random traffic with i_req held high, random back-pressure and config writes.
      acc_n = 0; guard = 0; pend = 1'b0;
      while (acc_n < 200 && guard < 20000) begin
         guard++;
         if (!pend) begin
            ch  = int'($urandom_range(0, 3));
            mid = int'($urandom_range(0, 2047));
            case ($urandom_range(0, 3))
               0:       addr = mid;
               1:       addr = int'($urandom_range(0, 2047));
               default: begin
                  addr = mid + int'($urandom_range(0, 80)) - 40;
                  if (addr < 0) addr = 0;
                  if (addr > 2047) addr = 2047;
               end
            endcase
            if ($urandom_range(0, 3) == 0)
               rise = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 50))
                                                  : 65535 - int'($urandom_range(0, 50));
            else
               rise = int'($urandom_range(0, 65535));
            i_ch = 2'(ch); i_addr_mid = 11'(mid); i_tdc_rd_addr = 11'(addr);
            i_rise_data = 16'(rise);
            i_post_sign = 1'($urandom_range(0, 1));
            i_now_sign  = 1'($urandom_range(0, 1));
            i_req = 1'b1;
            pend = 1'b1;
         end
         i_cfg_we    = ($urandom_range(0, 7) == 0);
         i_cfg_ch    = 2'($urandom_range(0, 3));
         i_cfg_sel   = 1'($urandom_range(0, 1));
         i_cfg_data  = 16'($urandom_range(0, 65535));
         i_out_ready = ($urandom_range(0, 3) != 0);
         if (o_ready && i_req) begin
            model(int'(i_ch), i_post_sign, i_now_sign, int'(i_addr_mid),
                  int'(i_tdc_rd_addr), int'(i_rise_data), ed, es, elat);
            sb.push_back('{ed, es, i_ch, cyc + 1, elat});
            pend = 1'b0;
            acc_n++;
         end
         if (i_cfg_we) begin
            if (i_cfg_sel) ref_hi[i_cfg_ch] = int'(i_cfg_data);
            else           ref_lo[i_cfg_ch] = int'(i_cfg_data);
         end
         @(posedge clk); #2;
      end
      check("random_accepts", 64'(acc_n), 64'd200);
      i_req = 1'b0; i_cfg_we = 1'b0; i_out_ready = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
